ddr_port1_scanout_reader: RTL and testbench
===========================================

# ddr_port1_scanout_reader

- Read-side DMA for the video framebuffer: fetches a frame of 32-bit pixel words from DDR2 through memory-controller port 1 and buffers them in a local FIFO.
- Presents the words in address order as a valid/ready stream to the display path.
- Is the consumer of what the port-0 write controller and rendering engine deposit in memory.
- Runs entirely in the memory user clock domain.

## Interface

Parameters:
- BASE_ADDR, 30'h0: byte address of pixel 0.
- FRAME_WORDS, 307200: words per frame. Must be a multiple of BURST_LEN.
- BURST_LEN, 32: words per read command. Range 1..64. Drives p1_cmd_bl = BURST_LEN-1.
- FIFO_DEPTH, 64: local FIFO depth in words. Power of two, ≥ BURST_LEN.

Ports:
- clk, in, 1: memory user clock (clk0); all logic on the rising edge.
- nreset, in, 1: asynchronous, active-low reset.
- mem_calib_done, in, 1: DDR calibration complete.
- enable, in, 1: allow fetching.
- frame_start, in, 1: one-cycle pulse that (re)starts the frame at BASE_ADDR.
- p1_cmd_en, out, 1: command strobe.
- p1_cmd_instr, out, 3: constant 3'b001 (read).
- p1_cmd_bl, out, 6: BURST_LEN-1.
- p1_cmd_byte_addr, out, 30: burst byte address.
- p1_cmd_full, in, 1: controller command FIFO full.
- p1_rd_en, out, 1: pop controller read FIFO.
- p1_rd_data, in, 32: read FIFO head (first-word-fall-through).
- p1_rd_empty, in, 1: read FIFO empty.
- pix_data, out, 32: stream data (local FIFO head).
- pix_valid, out, 1: stream valid.
- pix_ready, in, 1: consumer accepts.
- frame_done, out, 1: one-cycle pulse when the last frame word is accepted.
- underflow, out, 1: sticky error flag.

## Operation

**States**
- IDLE: no commands. Go to ISSUE on frame_start while mem_calib_done=1 and enable=1.
  - frame_start with mem_calib_done=0 or enable=0 is ignored.
- ISSUE: wait until all of the following hold: free local slots ≥ BURST_LEN, p1_cmd_full=0, enable=1. Then:
  - Assert p1_cmd_en for exactly one cycle with the current address.
  - Go to DRAIN.
- DRAIN:
  - p1_rd_en = !p1_rd_empty.
  - Each pop pushes p1_rd_data into the local FIFO and increments the burst word counter.
  - After BURST_LEN pops:
    - Advance address by BURST_LEN*4 bytes.
    - Add BURST_LEN to the fetched-word count.
    - If fetched count = FRAME_WORDS, go to DONE; otherwise go to ISSUE.
- DONE: wait for the consumer to accept all FRAME_WORDS words, then pulse frame_done. Go to IDLE.
- FLUSH: entered on frame_start while in ISSUE, DRAIN or DONE.
  - Pop and discard the remaining words of any issued, not-yet-drained burst.
  - Clear the local FIFO.
  - Reset address to BASE_ADDR and counters to 0.
  - Go to ISSUE.
  - frame_start during FLUSH is absorbed; restart still begins at BASE_ADDR.

**Pointers and flags**
- Only one burst is outstanding at any time.
- Address wraps modulo 2^30. The fetched-word counter is wide enough for FRAME_WORDS.
- Local FIFO: push when p1_rd_en & !p1_rd_empty in DRAIN; pop when pix_valid & pix_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Push is never attempted when full, guaranteed by the ISSUE check.
- pix_valid = local FIFO non-empty and not in FLUSH. pix_data = FIFO head.
- underflow:
  - Set when pix_ready=1 and pix_valid=0 while the frame is active. Active means after the first word is accepted and before frame_done.
  - Cleared only by frame_start or reset.
- If mem_calib_done drops, no new command is issued; the outstanding burst still drains.

## Timing

- Reset values: p1_cmd_en=0, p1_rd_en=0, p1_cmd_byte_addr=BASE_ADDR, pix_valid=0, frame_done=0, underflow=0, state IDLE.
- p1_cmd_instr and p1_cmd_bl are constant. p1_cmd_byte_addr is stable in the p1_cmd_en cycle.
- frame_start to first p1_cmd_en: 1 cycle minimum, registered.
- Read FIFO pop to pix_valid: 1 cycle; the pushed word is visible the next cycle.
- Throughput: one word per cycle in DRAIN while p1_rd_empty=0.
- frame_done asserts the cycle after the final pix handshake.
- Asserting nreset mid-burst returns to IDLE immediately.
  - Stale controller read data is not recovered by this block; memory reset accompanies it.

## Test plan

Tests use FRAME_WORDS=128, BURST_LEN=32, FIFO_DEPTH=64, BASE_ADDR=0x1000 with a port-1 memory model.

- Basic frame: calib=1, enable=1, frame_start, pix_ready=1.
  - Exactly 4 commands at 0x1000, 0x1080, 0x1100, 0x1180, bl=31, instr=001.
  - 128 words out in address order; one frame_done; underflow=0.
- Backpressure: pix_ready=0.
  - Two commands issued, 64 words buffered, no third command.
  - Raising pix_ready produces the third command once 32 words are freed.
- Command full: p1_cmd_full=1 for 50 cycles before the first command.
  - p1_cmd_en stays 0 throughout; the command issues the cycle after full clears.
- Mid-burst restart: frame_start after 10 words of burst 2.
  - The remaining 22 words are popped and discarded; the FIFO is emptied.
  - The next command is at 0x1000; the output restarts with word 0.
- Underflow: memory model delays read data 40 cycles while pix_ready=1 after word 5.
  - underflow=1 and stays set until the next frame_start.
- Reset/calib: nreset low mid-DRAIN gives all outputs at their reset values. mem_calib_done=0 with frame_start gives no command.

Source files
------------

// File: rtl/ddr_port1_scanout_reader_if.sv
// Port-1 read-command/read-data bus plus the outgoing pixel stream.
interface ddr_port1_scanout_reader_if;
  logic        p1_cmd_en;
  logic [2:0]  p1_cmd_instr;
  logic [5:0]  p1_cmd_bl;
  logic [29:0] p1_cmd_byte_addr;
  logic        p1_cmd_full;
  logic        p1_rd_en;
  logic [31:0] p1_rd_data;
  logic        p1_rd_empty;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  // Reader side: drives commands, read pops and the pixel stream.
  modport master (
    output p1_cmd_en, p1_cmd_instr, p1_cmd_bl, p1_cmd_byte_addr, p1_rd_en,
           pix_data, pix_valid,
    input  p1_cmd_full, p1_rd_data, p1_rd_empty, pix_ready
  );

  // Memory controller / display side.
  modport slave (
    input  p1_cmd_en, p1_cmd_instr, p1_cmd_bl, p1_cmd_byte_addr, p1_rd_en,
           pix_data, pix_valid,
    output p1_cmd_full, p1_rd_data, p1_rd_empty, pix_ready
  );
endinterface

// File: rtl/ddr_port1_scanout_reader.sv
// Framebuffer scan-out DMA: reads a frame from DDR port 1 in bursts and
// streams the words in address order through a local FIFO.
module ddr_port1_scanout_reader #(
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      mem_calib_done,
  input  logic                      enable,
  input  logic                      frame_start,
  ddr_port1_scanout_reader_if.master bus,
  output logic                      frame_done,
  output logic                      underflow
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [29:0] ADDR_STEP = 30'(BURST_LEN * 4);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, FLUSH} state_t;

  state_t        state, state_d;
  logic          cmd_en, cmd_en_d, frame_done_d;
  logic [29:0]   addr;
  logic [FW-1:0] fetched, accepted;
  logic [BW-1:0] burst_cnt;
  logic          pending;
  logic          active;
  logic [31:0]   fifo_mem [0:FIFO_DEPTH-1];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          rd_en_c, last_pop_c, push_c, pix_hs_c, pix_valid_c;
  logic          can_issue_c, restart_c, frame_full_c;
  logic [CW-1:0] free_c;

  assign free_c       = CW'(FIFO_DEPTH) - count;
  assign can_issue_c  = (free_c >= CW'(BURST_LEN)) && !bus.p1_cmd_full && enable && mem_calib_done;
  assign rd_en_c      = pending && !bus.p1_rd_empty && (state == DRAIN || state == FLUSH);
  assign last_pop_c   = rd_en_c && (burst_cnt == BW'(BURST_LEN - 1));
  assign push_c       = rd_en_c && (state == DRAIN);
  assign pix_valid_c  = (count != '0) && (state != FLUSH);
  assign pix_hs_c     = pix_valid_c && bus.pix_ready;
  assign frame_full_c = (fetched + FW'(BURST_LEN)) == FW'(FRAME_WORDS);
  // Any (re)start of a frame rewinds address, counters and the FIFO.
  assign restart_c    = (state == IDLE && state_d == ISSUE) || (state_d == FLUSH);

  assign bus.p1_cmd_en        = cmd_en;
  assign bus.p1_cmd_instr     = 3'b001;
  assign bus.p1_cmd_bl        = 6'(BURST_LEN - 1);
  assign bus.p1_cmd_byte_addr = addr;
  assign bus.p1_rd_en         = rd_en_c;
  assign bus.pix_valid        = pix_valid_c;
  assign bus.pix_data         = fifo_mem[rd_ptr];

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state;
    cmd_en_d     = 1'b0;
    frame_done_d = 1'b0;
    case (state)
      IDLE:  if (frame_start && mem_calib_done && enable) state_d = ISSUE;
      ISSUE: begin
        if (frame_start) state_d = FLUSH;
        else if (can_issue_c) begin
          cmd_en_d = 1'b1;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_start) state_d = FLUSH;
        else if (last_pop_c) state_d = frame_full_c ? DONE : ISSUE;
      end
      DONE: begin
        if (frame_start) state_d = FLUSH;
        else if (pix_hs_c && accepted == FW'(FRAME_WORDS - 1)) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      FLUSH: if (!pending || last_pop_c) state_d = ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // State, burst tracking, address/counters, FIFO pointers and flags.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      cmd_en     <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      addr       <= BASE_ADDR;
      fetched    <= '0;
      accepted   <= '0;
      burst_cnt  <= '0;
      pending    <= 1'b0;
      active     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_d;
      cmd_en     <= cmd_en_d;
      frame_done <= frame_done_d;

      if (cmd_en_d) pending <= 1'b1;
      if (rd_en_c) burst_cnt <= last_pop_c ? '0 : burst_cnt + BW'(1);
      if (last_pop_c) pending <= 1'b0;

      if (restart_c) begin
        addr     <= BASE_ADDR;
        fetched  <= '0;
        accepted <= '0;
        active   <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (state == DRAIN && last_pop_c) begin
          addr    <= addr + ADDR_STEP;
          fetched <= fetched + FW'(BURST_LEN);
        end
        if (push_c) wr_ptr <= wr_ptr + AW'(1);
        if (pix_hs_c) begin
          rd_ptr   <= rd_ptr + AW'(1);
          accepted <= accepted + FW'(1);
          active   <= 1'b1;
        end
        if (push_c && !pix_hs_c) count <= count + CW'(1);
        else if (!push_c && pix_hs_c) count <= count - CW'(1);
        if (frame_done_d) active <= 1'b0;
      end

      if (frame_start) underflow <= 1'b0;
      else if (active && bus.pix_ready && !pix_valid_c) underflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_c && !restart_c) fifo_mem[wr_ptr] <= bus.p1_rd_data;
  end
endmodule

// File: tb/tb_ddr_port1_scanout_reader.sv
// Bench for the scan-out reader: port-1 memory model with random latency,
// configurable consumer, directed scenarios checked against a frame model.
module tb_ddr_port1_scanout_reader;
  localparam logic [29:0] BASE = 30'h1000;
  localparam int unsigned NW   = 128;
  localparam int unsigned BL   = 32;

  typedef struct packed {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] addr;
  } cmd_t;

  logic clk, nreset, mem_calib_done, enable, frame_start, frame_done, underflow;
  ddr_port1_scanout_reader_if bus();

  ddr_port1_scanout_reader #(
    .BASE_ADDR(BASE), .FRAME_WORDS(NW), .BURST_LEN(BL), .FIFO_DEPTH(64)
  ) dut (
    .clk(clk), .nreset(nreset), .mem_calib_done(mem_calib_done), .enable(enable),
    .frame_start(frame_start), .bus(bus), .frame_done(frame_done), .underflow(underflow)
  );

  cmd_t        cmd_q[$];
  logic [31:0] rdq[$];
  logic [31:0] out_q[$];
  int unsigned lat, pops, done_cnt, cyc, last_hs_cyc, done_cyc;
  logic        stall;
  int          rmode;
  logic [31:0] seed;
  int          n_assert, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a scrambled function of the word address.
  function automatic logic [31:0] word(input logic [31:0] idx);
    return (idx * 32'h9E3779B1) ^ seed;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model and stream monitor, sampling pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (bus.p1_rd_en && !bus.p1_rd_empty && rdq.size() != 0) begin
      void'(rdq.pop_front());
      pops++;
    end
    if (bus.p1_cmd_en) begin
      cmd_q.push_back('{instr: bus.p1_cmd_instr, bl: bus.p1_cmd_bl, addr: bus.p1_cmd_byte_addr});
      for (int i = 0; i < int'(BL); i++)
        rdq.push_back(word(32'(bus.p1_cmd_byte_addr >> 2) + 32'(i)));
      lat = $urandom_range(1, 6);
    end else if (lat != 0) begin
      lat--;
    end
    if (bus.pix_valid && bus.pix_ready) begin
      out_q.push_back(bus.pix_data);
      last_hs_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // One cycle: drive memory outputs and the consumer at the falling edge.
  task automatic step();
    @(negedge clk);
    bus.p1_rd_empty = (rdq.size() == 0) || stall || (lat != 0);
    bus.p1_rd_data  = (rdq.size() != 0) ? rdq[0] : 32'h0;
    case (rmode)
      0:       bus.pix_ready = 1'b0;
      1:       bus.pix_ready = 1'b1;
      default: bus.pix_ready = bus.pix_valid && ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic clear_obs();
    cmd_q.delete();
    out_q.delete();
    pops     = 0;
    done_cnt = 0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    for (int n = 0; done_cnt == 0 && n < 4000; n++) step();
    repeat (4) step();
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
  endtask

  // Reference frame: NW consecutive words from BASE, issued as NW/BL bursts.
  task automatic check_frame(input string tag);
    check({tag, "_nwords"}, 64'(out_q.size()), 64'(NW));
    for (int i = 0; i < out_q.size() && i < int'(NW); i++)
      check({tag, "_word"}, 64'(out_q[i]), 64'(word(32'(BASE >> 2) + 32'(i))));
    check({tag, "_ncmd"}, 64'(cmd_q.size()), 64'(NW / BL));
    for (int i = 0; i < cmd_q.size() && i < int'(NW / BL); i++) begin
      check({tag, "_cmd_addr"}, 64'(cmd_q[i].addr), 64'(BASE + 30'(i * BL * 4)));
      check({tag, "_cmd_bl"}, 64'(cmd_q[i].bl), 64'(BL - 1));
      check({tag, "_cmd_instr"}, 64'(cmd_q[i].instr), 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    n_assert = 0; n_fail = 0; cyc = 0; lat = 0; stall = 1'b0; rmode = 0;
    seed = $urandom;
    clear_obs();
    nreset = 1'b0; mem_calib_done = 1'b1; enable = 1'b1; frame_start = 1'b0;
    bus.p1_cmd_full = 1'b0; bus.p1_rd_empty = 1'b1; bus.p1_rd_data = '0; bus.pix_ready = 1'b0;
    repeat (3) step();

    // Reset values
    check("rst_cmd_en", 64'(bus.p1_cmd_en), 64'd0);
    check("rst_rd_en", 64'(bus.p1_rd_en), 64'd0);
    check("rst_addr", 64'(bus.p1_cmd_byte_addr), 64'(BASE));
    check("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_instr", 64'(bus.p1_cmd_instr), 64'd1);
    check("rst_bl", 64'(bus.p1_cmd_bl), 64'(BL - 1));
    nreset = 1'b1;
    step();

    // Basic frame with a consumer that takes data whenever offered
    clear_obs(); rmode = 2;
    start_frame();
    check("basic_cmd_lat0", 64'(bus.p1_cmd_en), 64'd0);
    step();
    check("basic_cmd_lat1", 64'(bus.p1_cmd_en), 64'd1);
    wait_frame("basic");
    check_frame("basic");
    check("basic_done_timing", 64'(done_cyc), 64'(last_hs_cyc + 1));
    check("basic_underflow", 64'(underflow), 64'd0);

    // Backpressure: two bursts fill the FIFO, third waits for 32 free slots
    clear_obs(); rmode = 0;
    start_frame();
    repeat (300) step();
    check("bp_two_cmds", 64'(cmd_q.size()), 64'd2);
    check("bp_pops", 64'(pops), 64'd64);
    check("bp_valid", 64'(bus.pix_valid), 64'd1);
    rmode = 1;
    repeat (31) step();
    rmode = 0;
    repeat (50) step();
    check("bp_31_freed", 64'(cmd_q.size()), 64'd2);
    rmode = 1;
    step();
    rmode = 0;
    for (int n = 0; cmd_q.size() < 3 && n < 20; n++) step();
    check("bp_third_cmd", 64'(cmd_q.size()), 64'd3);
    rmode = 2;
    wait_frame("bp");
    check_frame("bp");

    // Command FIFO full delays the first command
    clear_obs(); rmode = 2;
    bus.p1_cmd_full = 1'b1;
    start_frame();
    repeat (50) step();
    check("full_no_cmd", 64'(cmd_q.size()), 64'd0);
    check("full_cmd_en", 64'(bus.p1_cmd_en), 64'd0);
    bus.p1_cmd_full = 1'b0;
    step();
    check("full_release", 64'(bus.p1_cmd_en), 64'd1);
    wait_frame("full");
    check_frame("full");

    // Restart after 10 words of burst 2
    clear_obs(); rmode = 0;
    start_frame();
    for (int n = 0; pops < 42 && n < 1000; n++) step();
    check("rs_reach", 64'(pops >= 42), 64'd1);
    frame_start = 1'b1;
    cmd_q.delete(); out_q.delete();
    step();
    frame_start = 1'b0;
    rmode = 2;
    wait_frame("rs");
    check_frame("rs");
    check("rs_total_pops", 64'(pops), 64'(64 + NW));
    check("rs_mem_empty", 64'(rdq.size()), 64'd0);

    // Underflow: read data stalls for 40 cycles with ready held high
    clear_obs(); rmode = 1;
    start_frame();
    step();
    check("uf_not_active", 64'(underflow), 64'd0);
    for (int n = 0; out_q.size() < 5 && n < 500; n++) step();
    stall = 1'b1;
    repeat (40) step();
    stall = 1'b0;
    check("uf_set", 64'(underflow), 64'd1);
    wait_frame("uf");
    check("uf_sticky", 64'(underflow), 64'd1);
    check_frame("uf");
    clear_obs(); rmode = 2;
    start_frame();
    check("uf_cleared", 64'(underflow), 64'd0);
    wait_frame("uf2");
    check_frame("uf2");
    check("uf2_underflow", 64'(underflow), 64'd0);

    // Reset mid-DRAIN of burst 2
    clear_obs(); rmode = 0;
    start_frame();
    for (int n = 0; pops < 40 && n < 1000; n++) step();
    check("rst2_reach", 64'(pops >= 40), 64'd1);
    nreset = 1'b0;
    #1;
    check("rst2_cmd_en", 64'(bus.p1_cmd_en), 64'd0);
    check("rst2_rd_en", 64'(bus.p1_rd_en), 64'd0);
    check("rst2_addr", 64'(bus.p1_cmd_byte_addr), 64'(BASE));
    check("rst2_pix_valid", 64'(bus.pix_valid), 64'd0);
    check("rst2_frame_done", 64'(frame_done), 64'd0);
    check("rst2_underflow", 64'(underflow), 64'd0);
    rdq.delete(); lat = 0;
    repeat (2) step();
    nreset = 1'b1;
    n0 = cmd_q.size();
    repeat (20) step();
    check("rst2_idle", 64'(cmd_q.size()), 64'(n0));

    // frame_start ignored without calibration or enable
    mem_calib_done = 1'b0;
    start_frame();
    repeat (50) step();
    check("calib_no_cmd", 64'(cmd_q.size()), 64'(n0));
    mem_calib_done = 1'b1;
    repeat (20) step();
    check("calib_stays_idle", 64'(cmd_q.size()), 64'(n0));
    enable = 1'b0;
    start_frame();
    enable = 1'b1;
    repeat (30) step();
    check("enable_no_cmd", 64'(cmd_q.size()), 64'(n0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
